// File: rtl/reg_ctrl_pkg.sv
// Shared types and constants for the register-file write arbiter.
package reg_ctrl_pkg;

   localparam int PW   = 2;
   localparam int DW   = 8;
   localparam int NREG = 2 ** PW;

   typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;

   typedef struct packed {
      logic [PW-1:0] addr;
      logic [DW-1:0] data;
   } wr_req_t;

endpackage : reg_ctrl_pkg

// File: rtl/reg_write_arb_if.sv
// Bus bundle between writeback requesters, issue logic and reg_file write port.
interface reg_write_arb_if
   import reg_ctrl_pkg::*;
#(
   parameter int pw = PW,
   parameter int dw = DW
);
   logic              hold;
   logic              a_valid;
   logic [pw-1:0]     a_addr;
   logic [dw-1:0]     a_data;
   logic              a_ready;
   logic              b_valid;
   logic [pw-1:0]     b_addr;
   logic [dw-1:0]     b_data;
   logic              b_ready;
   logic              rsv_en;
   logic [pw-1:0]     rsv_addr;
   logic [2**pw-1:0]  busy;
   logic              rsv_conflict;
   logic              wr_en;
   logic [pw-1:0]     wr_addr;
   logic [dw-1:0]     wr_data;

   modport master (
      output hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
             rsv_en, rsv_addr,
      input  a_ready, b_ready, busy, rsv_conflict, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
             rsv_en, rsv_addr,
      output a_ready, b_ready, busy, rsv_conflict, wr_en, wr_addr, wr_data
   );

endinterface : reg_write_arb_if

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; remembers the last winner and favours the other.
module rr_arb2
   import reg_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       hold,
   output logic [1:0] gnt,
   output req_id_t    gnt_id
);

   req_id_t    r_last;
   logic [1:0] w_gnt;

   // Grant decode: hold blocks everything, a lone requester wins, a tie goes to the non-last side.
   always_comb begin
      w_gnt = 2'b00;
      if (hold) begin
         w_gnt = 2'b00;
      end else begin
         case (req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = (r_last == REQ_B) ? 2'b01 : 2'b10;
            default: w_gnt = 2'b00;
         endcase
      end
   end

   // Winner identity for the data mux and the last-winner update.
   always_comb begin
      gnt_id = REQ_A;
      if (w_gnt[1]) begin
         gnt_id = REQ_B;
      end else begin
         gnt_id = REQ_A;
      end
   end

   // Last-winner flop; starts at B so A wins the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= REQ_B;
      end else if (|w_gnt) begin
         r_last <= gnt_id;
      end else begin
         r_last <= r_last;
      end
   end

   assign gnt = w_gnt;

endmodule : rr_arb2

// File: rtl/reg_write_arb.sv
// Arbitrates the single reg_file write port between ALU (A) and load return (B),
// registers the write, and tracks pending destination registers for RAW stalls.
module reg_write_arb
   import reg_ctrl_pkg::*;
#(
   parameter int pw = PW,
   parameter int dw = DW
)(
   input  logic             clk,
   input  logic             rst_n,
   reg_write_arb_if.slave   s_bus
);

   localparam int NR = 2 ** pw;

   logic [1:0]     w_gnt;
   req_id_t        w_gnt_id;
   logic           w_xfer;
   wr_req_t        w_win;
   logic [NR-1:0]  w_busy_nxt;
   logic           w_conflict_nxt;

   logic           r_wr_en;
   logic [pw-1:0]  r_wr_addr;
   logic [dw-1:0]  r_wr_data;
   logic [NR-1:0]  r_busy;
   logic           r_rsv_conflict;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({s_bus.b_valid, s_bus.a_valid}),
      .hold   (s_bus.hold),
      .gnt    (w_gnt),
      .gnt_id (w_gnt_id)
   );

   assign w_xfer = |w_gnt;

   // Select the winning requester's address and data.
   always_comb begin
      w_win = '0;
      if (w_gnt_id == REQ_B) begin
         w_win.addr = s_bus.b_addr;
         w_win.data = s_bus.b_data;
      end else begin
         w_win.addr = s_bus.a_addr;
         w_win.data = s_bus.a_data;
      end
   end

   // Output register: a transfer becomes a reg_file write next cycle; idle keeps addr/data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (w_xfer) begin
         r_wr_en   <= 1'b1;
         r_wr_addr <= w_win.addr;
         r_wr_data <= w_win.data;
      end else begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= r_wr_addr;
         r_wr_data <= r_wr_data;
      end
   end

   // Scoreboard next state: a reservation outranks a commit because a newer owner has taken the register.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int r = 0; r < NR; r++) begin
         if (s_bus.rsv_en && (s_bus.rsv_addr == pw'(r))) begin
            w_busy_nxt[r] = 1'b1;
         end else if (r_wr_en && (r_wr_addr == pw'(r))) begin
            w_busy_nxt[r] = 1'b0;
         end else begin
            w_busy_nxt[r] = r_busy[r];
         end
      end
   end

   // Conflict when reserving a register that is busy and not being released this cycle.
   always_comb begin
      w_conflict_nxt = 1'b0;
      if (s_bus.rsv_en && r_busy[s_bus.rsv_addr] &&
          !(r_wr_en && (r_wr_addr == s_bus.rsv_addr))) begin
         w_conflict_nxt = 1'b1;
      end else begin
         w_conflict_nxt = 1'b0;
      end
   end

   // Scoreboard and conflict-pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy         <= '0;
         r_rsv_conflict <= 1'b0;
      end else begin
         r_busy         <= w_busy_nxt;
         r_rsv_conflict <= w_conflict_nxt;
      end
   end

   assign s_bus.a_ready      = w_gnt[0];
   assign s_bus.b_ready      = w_gnt[1];
   assign s_bus.busy         = r_busy;
   assign s_bus.rsv_conflict = r_rsv_conflict;
   assign s_bus.wr_en        = r_wr_en;
   assign s_bus.wr_addr      = r_wr_addr;
   assign s_bus.wr_data      = r_wr_data;

endmodule : reg_write_arb

// File: tb/tb_reg_write_arb.sv
// Directed bench: expected reg_file writes are queued at issue time and checked by a monitor.
module tb_reg_write_arb;
   import reg_ctrl_pkg::*;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   wr_req_t exp_q[$];

   reg_write_arb_if #(.pw(2), .dw(8)) bus ();

   reg_write_arb #(.pw(2), .dw(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [1:0] addr, input logic [7:0] data);
      wr_req_t e;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monitor: every reg_file write must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                     bus.wr_addr, bus.wr_data);
         end else begin
            wr_req_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
            chk("wr_data", 32'(bus.wr_data), 32'(e.data));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "timeout");
   end

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      bus.hold = 1'b0;
      bus.a_valid = 1'b0; bus.a_addr = 2'd0; bus.a_data = 8'h00;
      bus.b_valid = 1'b0; bus.b_addr = 2'd0; bus.b_data = 8'h00;
      bus.rsv_en = 1'b0;  bus.rsv_addr = 2'd0;
      #1;
      chk("reset_wr_en", 32'(bus.wr_en), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_conflict", 32'(bus.rsv_conflict), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Contention: A and B alternate starting with A.
      bus.a_valid = 1'b1; bus.a_addr = 2'd1; bus.a_data = 8'h11;
      bus.b_valid = 1'b1; bus.b_addr = 2'd2; bus.b_data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cont_a_ready", 32'(bus.a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_b_ready", 32'(bus.b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
         if (i % 2 == 0) expect_wr(2'd1, 8'h11);
         else            expect_wr(2'd2, 8'h22);
         cyc();
         if (i > 0) chk("cont_wr_en_cont", 32'(bus.wr_en), 32'd1);
      end
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;

      // Single requester B.
      bus.b_valid = 1'b1; bus.b_addr = 2'd3; bus.b_data = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("single_b_ready", 32'(bus.b_ready), 32'd1);
         chk("single_a_ready", 32'(bus.a_ready), 32'd0);
         expect_wr(2'd3, 8'hA5);
         cyc();
      end

      // Hold: both valid, nothing granted; last committed write still lands.
      bus.hold = 1'b1;
      bus.a_valid = 1'b1; bus.a_addr = 2'd1; bus.a_data = 8'h11;
      bus.b_addr = 2'd2; bus.b_data = 8'h22;
      #1;
      chk("hold_a_ready_0", 32'(bus.a_ready), 32'd0);
      chk("hold_b_ready_0", 32'(bus.b_ready), 32'd0);
      cyc();
      #1;
      chk("hold_a_ready_1", 32'(bus.a_ready), 32'd0);
      chk("hold_b_ready_1", 32'(bus.b_ready), 32'd0);
      chk("hold_wr_en", 32'(bus.wr_en), 32'd0);
      cyc();
      bus.hold = 1'b0;
      #1;
      chk("resume_a_first", 32'(bus.a_ready), 32'd1);
      expect_wr(2'd1, 8'h11);
      cyc();
      #1;
      chk("resume_b_next", 32'(bus.b_ready), 32'd1);
      expect_wr(2'd2, 8'h22);
      cyc();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      cyc();

      // Scoreboard: reserve, then commit clears it.
      bus.rsv_en = 1'b1; bus.rsv_addr = 2'd2;
      cyc();
      bus.rsv_en = 1'b0;
      chk("sb_reserve", 32'(bus.busy), 32'h4);
      chk("sb_no_conflict", 32'(bus.rsv_conflict), 32'd0);
      bus.a_valid = 1'b1; bus.a_addr = 2'd2; bus.a_data = 8'h33;
      #1;
      chk("sb_a_ready", 32'(bus.a_ready), 32'd1);
      expect_wr(2'd2, 8'h33);
      cyc();
      bus.a_valid = 1'b0;
      chk("sb_busy_during_wr", 32'(bus.busy), 32'h4);
      cyc();
      chk("sb_cleared", 32'(bus.busy), 32'h0);

      // Reserve in the same cycle as the commit keeps the bit set.
      bus.rsv_en = 1'b1; bus.rsv_addr = 2'd2;
      cyc();
      bus.rsv_en = 1'b0;
      bus.a_valid = 1'b1; bus.a_addr = 2'd2; bus.a_data = 8'h44;
      expect_wr(2'd2, 8'h44);
      cyc();
      bus.a_valid = 1'b0;
      bus.rsv_en = 1'b1; bus.rsv_addr = 2'd2;
      cyc();
      bus.rsv_en = 1'b0;
      chk("sb_same_cycle_busy", 32'(bus.busy), 32'h4);
      chk("sb_same_cycle_no_conflict", 32'(bus.rsv_conflict), 32'd0);

      // Conflict: reserving register 0 twice.
      bus.rsv_en = 1'b1; bus.rsv_addr = 2'd0;
      cyc();
      chk("cf_first_no_conflict", 32'(bus.rsv_conflict), 32'd0);
      cyc();
      bus.rsv_en = 1'b0;
      chk("cf_conflict", 32'(bus.rsv_conflict), 32'd1);
      chk("cf_busy", 32'(bus.busy), 32'h5);
      cyc();
      chk("cf_one_cycle", 32'(bus.rsv_conflict), 32'd0);

      // Reset mid-burst: last winner was A, so B wins the tie.
      bus.a_valid = 1'b1; bus.a_addr = 2'd1; bus.a_data = 8'h11;
      bus.b_valid = 1'b1; bus.b_addr = 2'd2; bus.b_data = 8'h22;
      #1;
      chk("pre_rst_b_ready", 32'(bus.b_ready), 32'd1);
      expect_wr(2'd2, 8'h22);
      cyc();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("pre_rst_wr_en", 32'(bus.wr_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_conflict", 32'(bus.rsv_conflict), 32'd0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
      cyc();
      rst_n = 1'b1;
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b1;
      #1;
      chk("post_rst_a_first", 32'(bus.a_ready), 32'd1);
      chk("post_rst_b_wait", 32'(bus.b_ready), 32'd0);
      expect_wr(2'd1, 8'h11);
      cyc();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      repeat (3) cyc();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_reg_write_arb

// File: doc/reg_write_arb.md
Name: reg_write_arb

Overview:
- Shares the single write port of reg_file between two writeback requesters:
  - A: ALU result path.
  - B: data-memory load return.
- Uses valid/ready handshakes and round-robin priority. The write toward reg_file is registered.
- Holds a per-register busy scoreboard. Issue logic reserves destination registers; the scoreboard clears each entry when that register's write commits. Decode uses the busy bits for RAW stall detection.
- Sits between the writeback stage and reg_file. Drives reg_file wr_en/wr_addr/dat_in.

Parameters:
- pw, 2, register address width (2**pw registers); must match reg_file pw.
- dw, 8, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  freeze: no new write accepted while 1.
- a_valid  in  1  requester A has a write.
- a_addr  in  pw  A destination register.
- a_data  in  dw  A write data.
- a_ready  out  1  A accepted this cycle (combinational).
- b_valid  in  1  requester B has a write.
- b_addr  in  pw  B destination register.
- b_data  in  dw  B write data.
- b_ready  out  1  B accepted this cycle (combinational).
- rsv_en  in  1  reserve a destination register.
- rsv_addr  in  pw  register to reserve.
- busy  out  2**pw  scoreboard; bit r=1 means register r has a pending write.
- rsv_conflict  out  1  registered pulse: reserve hit an already-busy register.
- wr_en  out  1  to reg_file wr_en.
- wr_addr  out  pw  to reg_file wr_addr.
- wr_data  out  dw  to reg_file dat_in.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, rsv_conflict=0.
  - RR pointer last=B, so A has priority first.
  - Any accepted-but-uncommitted write is discarded.
- Handshake:
  - A transfer occurs when valid & ready are both 1 at a rising edge.
  - Requesters hold addr/data stable while valid=1 and ready=0.
  - ready never depends on the requester's own data.
- Grant, combinational, at most one grant per cycle:
  - hold=1: a_ready=b_ready=0.
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to last.
  - last updates to the granted requester on every transfer. It is unchanged when there is no transfer.
- Write output register, 1-cycle latency:
  - Transfer at edge N: wr_en=1, wr_addr/wr_data = winner's addr/data in cycle N+1.
  - No transfer: wr_en=0 next cycle. wr_addr/wr_data hold their previous values.
  - Back-to-back transfers give a continuous wr_en=1.
- Scoreboard, per bit r at each edge, evaluated in this order:
  - set if rsv_en & rsv_addr==r;
  - else clear if wr_en & wr_addr==r;
  - else hold.
  - Reserve and commit to the same register in the same cycle leaves busy=1, because a newer instruction now owns it.
  - Commit to a non-busy register is legal; busy stays 0.
- rsv_conflict:
  - Registered. It is 1 in the cycle after rsv_en=1 with busy[rsv_addr]=1 and no same-cycle commit clearing it.
  - Otherwise 0.
  - Single-entry scoreboard, no count.
- Throughput: 1 write/cycle total. The worst-case wait for a continuously-valid requester is 1 cycle.
- hold asserted mid-burst: the output already registered still commits. Nothing new is accepted until hold=0.

Decomposition:
- Package reg_ctrl_pkg:
  - constants PW=2, DW=8, NREG=2**PW;
  - typedef enum logic {REQ_A, REQ_B} req_id_t;
  - typedef struct {logic[PW-1:0] addr; logic[DW-1:0] data;} wr_req_t.
- Sub-module rr_arb2: 2-way round-robin arbiter with its own last flop. Inputs: clk, rst_n, req[1:0], hold. Outputs: gnt[1:0] (combinational), gnt_id.
- Scoreboard and output register stay in reg_write_arb.

Test Plan:
- Reset: drive rst_n=0 mid-burst with wr_en=1 → wr_en=0, busy=4'b0000, rsv_conflict=0 immediately, before any clock edge. After release, A and B both valid → A granted first.
- Contention: A (addr 1, data 8'h11) and B (addr 2, data 8'h22) held valid 4 cycles.
  - Grants alternate A,B,A,B.
  - wr_en high on 4 consecutive cycles, lagging by 1.
  - wr_addr sequence 1,2,1,2 with matching data.
- Single requester: B alone, addr 3, data 8'hA5, for 3 cycles → b_ready=1 every cycle; wr_en=1 on 3 cycles; a_ready=0 throughout.
- Hold: both valid with hold=1 for 2 cycles → a_ready=b_ready=0; wr_en=0 from the second cycle. Release hold → grant order resumes from the unchanged last.
- Scoreboard: rsv_en addr 2 → busy=4'b0100. A writes addr 2 → busy clears the cycle after wr_en. Reserve addr 2 in the same cycle as the commit to addr 2 → busy[2] stays 1.
- Conflict: reserve addr 0 twice with no commit between → rsv_conflict=1 for exactly one cycle; busy[0]=1.
